// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch redirects,
// fetch-wait handling with a held redirect target, saturating perf counters and a fetch timeout.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned FETCH_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic [4:0]       RD_EX,
  input  logic             MemRead_EX,
  input  logic             PCSrc_EX,
  input  logic [31:0]      PC_Branch_EX,
  input  logic             imem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             PCSrc,
  output logic [31:0]      PC_Branch,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic             fetch_timeout
);

  typedef enum logic [1:0] {
    StRun          = 2'd0,
    StFetchWait    = 2'd1,
    StRedirectHold = 2'd2
  } state_e;

  localparam int unsigned WaitW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(FETCH_TIMEOUT);

  state_e           state_q, state_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, redirect_cnt_q;
  logic             fetch_timeout_q;
  logic             load_use;
  logic             waiting;

  assign load_use = MemRead_EX && (RD_EX != 5'd0) && ((RD_EX == RS1_ID) || (RD_EX == RS2_ID));

  always_comb begin
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    PCSrc       = 1'b0;
    PC_Branch   = PC_Branch_EX;
    state_d     = state_q;
    pend_tgt_d  = pend_tgt_q;
    if (reset) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      PC_Branch   = 32'd0;
      state_d     = StRun;
      pend_tgt_d  = 32'd0;
    end else begin
      unique case (state_q)
        StRun, StFetchWait: begin
          if (PCSrc_EX) begin
            // Branch wins over load-use: the dependent instruction is squashed anyway.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            if (imem_ready) begin
              PCSrc   = 1'b1;
              state_d = StRun;
            end else begin
              PC_write    = 1'b0;
              IF_ID_write = 1'b0;
              pend_tgt_d  = PC_Branch_EX;
              state_d     = StRedirectHold;
            end
          end else if (load_use) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            state_d     = imem_ready ? StRun : StFetchWait;
          end else if (!imem_ready) begin
            PC_write    = 1'b0;
            IF_ID_flush = 1'b1;
            state_d     = StFetchWait;
          end else begin
            state_d = StRun;
          end
        end
        StRedirectHold: begin
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
          IF_ID_write = 1'b0;
          if (imem_ready) begin
            PCSrc     = 1'b1;
            PC_Branch = pend_tgt_q;
            state_d   = StRun;
          end else begin
            PC_write = 1'b0;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  assign waiting = !imem_ready &&
                   ((state_q != StRun) || (state_d == StFetchWait) ||
                    (state_d == StRedirectHold));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (imem_ready) begin
      wait_cnt_d = '0;
    end else if (waiting && (wait_cnt_q != WaitMax)) begin
      wait_cnt_d = wait_cnt_q + WaitW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StRun;
      pend_tgt_q      <= 32'd0;
      wait_cnt_q      <= '0;
      stall_cnt_q     <= '0;
      redirect_cnt_q  <= '0;
      fetch_timeout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
      wait_cnt_q <= wait_cnt_d;
      if (wait_cnt_d == WaitMax) begin
        fetch_timeout_q <= 1'b1;
      end
      if (!PC_write && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (PCSrc && (redirect_cnt_q != '1)) begin
        redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
      end
    end
  end

  assign state         = state_q;
  assign stall_cnt     = stall_cnt_q;
  assign redirect_cnt  = redirect_cnt_q;
  assign fetch_timeout = fetch_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios then random traffic, each cycle
// compared against a cycle-level reference model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CntW = 4;
  localparam int unsigned Ft   = 8;
  localparam int CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      RS1_ID, RS2_ID, RD_EX;
  logic            MemRead_EX, PCSrc_EX, imem_ready;
  logic [31:0]     PC_Branch_EX;
  logic            PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, PCSrc;
  logic [31:0]     PC_Branch;
  logic [1:0]      state;
  logic [CntW-1:0] stall_cnt, redirect_cnt;
  logic            fetch_timeout;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .CNT_W        (CntW),
    .FETCH_TIMEOUT(Ft)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RS1_ID       (RS1_ID),
    .RS2_ID       (RS2_ID),
    .RD_EX        (RD_EX),
    .MemRead_EX   (MemRead_EX),
    .PCSrc_EX     (PCSrc_EX),
    .PC_Branch_EX (PC_Branch_EX),
    .imem_ready   (imem_ready),
    .PC_write     (PC_write),
    .IF_ID_write  (IF_ID_write),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_flush  (ID_EX_flush),
    .PCSrc        (PCSrc),
    .PC_Branch    (PC_Branch),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .redirect_cnt (redirect_cnt),
    .fetch_timeout(fetch_timeout)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=run, 1=waiting for fetch, 2=holding a redirect.
  int          m_mode  = 0;
  logic [31:0] m_tgt   = 32'd0;
  int          m_wait  = 0;
  int          m_stall = 0;
  int          m_redir = 0;
  bit          m_to    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Evaluate one cycle with the currently driven inputs, check, then advance the model.
  task automatic step();
    bit lu, e_pcw, e_ifw, e_iff, e_exf, e_src;
    logic [31:0] e_br, n_tgt;
    int n_mode;
    #1;
    lu = MemRead_EX && (RD_EX != 0) && (RD_EX == RS1_ID || RD_EX == RS2_ID);
    e_pcw = 1; e_ifw = 1; e_iff = 0; e_exf = 0; e_src = 0;
    e_br = PC_Branch_EX; n_mode = 0; n_tgt = m_tgt;
    if (reset) begin
      e_pcw = 0; e_ifw = 0; e_iff = 1; e_exf = 1; e_br = 32'd0;
    end else if (m_mode == 2) begin
      e_iff = 1; e_exf = 1; e_ifw = 0;
      if (imem_ready) begin
        e_src = 1; e_br = m_tgt; n_mode = 0;
      end else begin
        e_pcw = 0; n_mode = 2;
      end
    end else if (PCSrc_EX) begin
      e_iff = 1; e_exf = 1;
      if (imem_ready) begin
        e_src = 1;
      end else begin
        e_pcw = 0; e_ifw = 0; n_tgt = PC_Branch_EX; n_mode = 2;
      end
    end else if (lu) begin
      e_pcw = 0; e_ifw = 0; e_exf = 1; n_mode = imem_ready ? 0 : 1;
    end else if (!imem_ready) begin
      e_pcw = 0; e_iff = 1; n_mode = 1;
    end
    check_eq("PC_write", PC_write, e_pcw);
    check_eq("IF_ID_write", IF_ID_write, e_ifw);
    check_eq("IF_ID_flush", IF_ID_flush, e_iff);
    check_eq("ID_EX_flush", ID_EX_flush, e_exf);
    check_eq("PCSrc", PCSrc, e_src);
    check_eq("PC_Branch", PC_Branch, e_br);
    check_eq("state", state, m_mode);
    check_eq("stall_cnt", stall_cnt, m_stall);
    check_eq("redirect_cnt", redirect_cnt, m_redir);
    check_eq("fetch_timeout", fetch_timeout, m_to);
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_tgt = 32'd0; m_wait = 0; m_stall = 0; m_redir = 0; m_to = 0;
    end else begin
      // Any not-ready cycle is either spent in, or entering, a wait state.
      m_wait = imem_ready ? 0 : ((m_wait + 1 > Ft) ? Ft : m_wait + 1);
      if (m_wait == Ft) m_to = 1;
      if (!e_pcw && m_stall < CntMax) m_stall++;
      if (e_src && m_redir < CntMax) m_redir++;
      m_mode = n_mode;
      m_tgt  = n_tgt;
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input bit mr, input bit src,
                     input logic [31:0] tgt, input bit rdy);
    reset = rst; RS1_ID = rs1; RS2_ID = rs2; RD_EX = rd;
    MemRead_EX = mr; PCSrc_EX = src; PC_Branch_EX = tgt; imem_ready = rdy;
    step();
  endtask

  initial begin
    reset = 1; RS1_ID = 0; RS2_ID = 0; RD_EX = 0;
    MemRead_EX = 0; PCSrc_EX = 0; PC_Branch_EX = 0; imem_ready = 1;
    @(negedge clk);
    @(negedge clk);
    // Reset held, then release into a clean run.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 32'h0, 1);
    cyc(0, 1, 2, 3, 0, 0, 32'h0, 1);
    check_eq("rel_state", state, 2'd0);
    // Load-use on rs2, then the same with x0 as destination.
    cyc(0, 1, 5, 5, 1, 0, 32'h0, 1);
    cyc(0, 1, 2, 3, 0, 0, 32'h0, 1);
    check_eq("lu_stall", stall_cnt, 1);
    cyc(0, 0, 0, 0, 1, 0, 32'h0, 1);
    // Branch together with load-use, fetch ready.
    cyc(0, 7, 6, 6, 1, 1, 32'h40, 1);
    cyc(0, 1, 2, 3, 0, 0, 32'h0, 1);
    check_eq("br_redir", redirect_cnt, 1);
    // Branch during a fetch wait; the later target on the bus must be ignored.
    cyc(0, 1, 2, 3, 0, 1, 32'h100, 0);
    for (int i = 0; i < 4; i++) cyc(0, 4, 4, 4, 1, 1, 32'h200, 0);
    cyc(0, 1, 2, 3, 0, 0, 32'h200, 1);
    check_eq("hold_tgt_redir", redirect_cnt, 2);
    // Long fetch stall: timeout flag and counter saturation.
    for (int i = 0; i < 10; i++) cyc(0, 1, 2, 3, 0, 0, 32'h0, 0);
    cyc(0, 1, 2, 3, 0, 0, 32'h0, 1);
    check_eq("to_sticky", fetch_timeout, 1'b1);
    for (int i = 0; i < 20; i++) cyc(0, 1, 2, 3, 0, 0, 32'h0, 0);
    cyc(0, 1, 2, 3, 0, 0, 32'h0, 1);
    check_eq("stall_sat", stall_cnt, 4'd15);
    cyc(1, 0, 0, 0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 1);
    check_eq("to_cleared", fetch_timeout, 1'b0);
    // Random traffic with occasional resets and long fetch stalls.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) == 0),
          5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
          ($urandom_range(9) < 4), ($urandom_range(9) < 2), $urandom,
          ((i % 400) < 12) ? 1'b0 : ($urandom_range(9) < 7));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
